// File: rtl/trigger_frame_builder.sv
// Collects triggered sample words per frame and emits one AXI4-Stream packet
// per frame: header, stored data words, footer (TLAST). Input has no backpressure.
module trigger_frame_builder #(
    parameter int SAMPLE_DATA_WIDTH    = 128,
    parameter int TRIGGER_INFO_WIDTH   = 8,
    parameter int TIMESTAMP_WIDTH      = 48,
    parameter int TRIGGER_CONFIG_WIDTH = 32,
    parameter int CHANNEL_ID           = 0,
    parameter int DATA_FIFO_DEPTH      = 64,
    parameter int INFO_FIFO_DEPTH      = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [TRIGGER_CONFIG_WIDTH+TIMESTAMP_WIDTH+TRIGGER_INFO_WIDTH+SAMPLE_DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                         S_AXIS_TVALID,
    output logic [SAMPLE_DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                         M_AXIS_TVALID,
    input  logic                         M_AXIS_TREADY,
    output logic                         M_AXIS_TLAST,
    output logic [15:0]                  DROP_COUNT
);
    localparam int SW   = SAMPLE_DATA_WIDTH;
    localparam int INW  = TRIGGER_INFO_WIDTH;
    localparam int TW   = TIMESTAMP_WIDTH;
    localparam int CW   = TRIGGER_CONFIG_WIDTH;
    localparam int IN_W = CW + TW + INW + SW;
    localparam int DW   = $clog2(DATA_FIFO_DEPTH);
    localparam int IW   = $clog2(INFO_FIFO_DEPTH);

    typedef struct packed {
        logic [TW-1:0]  end_ts;
        logic [1:0]     flags;
        logic [15:0]    len;
        logic [CW-1:0]  cfg;
        logic [TW-1:0]  start_ts;
        logic [INW-1:0] start_info;
    } frame_rec_t;

    typedef enum logic [1:0] {IN_IDLE, IN_FRAME, IN_DROP} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, HEADER, DATA, FOOTER} out_state_t;

    // input register stage
    logic [IN_W-1:0] w_q;
    logic            w_vld;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_q   <= '0;
            w_vld <= 1'b0;
        end else begin
            w_q   <= S_AXIS_TDATA;
            w_vld <= S_AXIS_TVALID;
        end
    end

    logic [SW-1:0]  w_samples;
    logic [INW-1:0] w_info;
    logic [TW-1:0]  w_ts;
    logic [CW-1:0]  w_cfg;
    logic           w_start, w_end;

    assign w_samples = w_q[SW-1:0];
    assign w_info    = w_q[SW +: INW];
    assign w_ts      = w_q[SW+INW +: TW];
    assign w_cfg     = w_q[SW+INW+TW +: CW];
    assign w_start   = w_info[0];
    assign w_end     = w_info[1];

    in_state_t      in_st;
    logic [INW-1:0] cur_info;
    logic [TW-1:0]  cur_ts;
    logic [CW-1:0]  cur_cfg;
    logic [15:0]    cur_len;
    logic           cur_trunc;
    logic [15:0]    drop_count;

    logic [DW:0]    data_cnt;
    logic [IW:0]    info_cnt;
    logic           data_pop, info_pop;

    logic           close_missing, restart_req, new_start, store_here;
    logic           data_space, data_push, info_push, info_ok, trunc_now;
    logic [15:0]    len_base, len_now;
    logic [IW:0]    info_level;
    frame_rec_t     push_rec;

    always_comb begin
        close_missing = w_vld && (in_st == IN_FRAME) && w_start && !w_end;
        restart_req   = w_vld && w_start && ((in_st != IN_FRAME) || !w_end);
        // a missing-end close pushes a record in the same cycle as the new start
        info_level    = info_cnt + (IW+1)'(close_missing) - (IW+1)'(info_pop);
        info_ok       = info_level < (IW+1)'(INFO_FIFO_DEPTH);
        new_start     = restart_req && info_ok;
        store_here    = new_start || (w_vld && (in_st == IN_FRAME) && !close_missing);
        data_space    = (data_cnt != (DW+1)'(DATA_FIFO_DEPTH)) || data_pop;
        data_push     = store_here && data_space;
        len_base      = new_start ? 16'd0 : cur_len;
        len_now       = (data_push && len_base != 16'hFFFF) ? len_base + 16'd1 : len_base;
        trunc_now     = (new_start ? 1'b0 : cur_trunc) | (store_here && !data_space);
        info_push     = close_missing || (store_here && w_end);
        if (close_missing) begin
            push_rec = '{end_ts: w_ts, flags: {1'b1, cur_trunc}, len: cur_len,
                         cfg: cur_cfg, start_ts: cur_ts, start_info: cur_info};
        end else begin
            push_rec = '{end_ts: w_ts, flags: {1'b0, trunc_now}, len: len_now,
                         cfg: new_start ? w_cfg : cur_cfg,
                         start_ts: new_start ? w_ts : cur_ts,
                         start_info: new_start ? w_info : cur_info};
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            in_st      <= IN_IDLE;
            cur_info   <= '0;
            cur_ts     <= '0;
            cur_cfg    <= '0;
            cur_len    <= '0;
            cur_trunc  <= 1'b0;
            drop_count <= '0;
        end else if (w_vld) begin
            if (new_start) begin
                cur_info <= w_info;
                cur_ts   <= w_ts;
                cur_cfg  <= w_cfg;
            end
            if (store_here) begin
                cur_len   <= len_now;
                cur_trunc <= trunc_now;
            end
            if (restart_req && !info_ok) begin
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                in_st <= w_end ? IN_IDLE : IN_DROP;
            end else if (new_start || in_st == IN_FRAME) begin
                in_st <= w_end ? IN_IDLE : IN_FRAME;
            end else if (in_st == IN_DROP && w_end) begin
                in_st <= IN_IDLE;
            end
        end
    end

    assign DROP_COUNT = drop_count;

    // data FIFO
    logic [SW-1:0] dmem [DATA_FIFO_DEPTH];
    logic [DW-1:0] d_wr, d_rd;

    always_ff @(posedge ACLK) begin
        if (data_push) dmem[d_wr] <= w_samples;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            d_wr     <= '0;
            d_rd     <= '0;
            data_cnt <= '0;
        end else begin
            if (data_push) d_wr <= d_wr + 1'b1;
            if (data_pop)  d_rd <= d_rd + 1'b1;
            data_cnt <= data_cnt + (DW+1)'(data_push) - (DW+1)'(data_pop);
        end
    end

    // frame-info FIFO
    frame_rec_t    imem [INFO_FIFO_DEPTH];
    logic [IW-1:0] i_wr, i_rd;
    frame_rec_t    head;

    assign head = imem[i_rd];

    always_ff @(posedge ACLK) begin
        if (info_push) imem[i_wr] <= push_rec;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            i_wr     <= '0;
            i_rd     <= '0;
            info_cnt <= '0;
        end else begin
            if (info_push) i_wr <= i_wr + 1'b1;
            if (info_pop)  i_rd <= i_rd + 1'b1;
            info_cnt <= info_cnt + (IW+1)'(info_push) - (IW+1)'(info_pop);
        end
    end

    // output side
    out_state_t    out_st;
    logic [15:0]   rem;
    logic          hs;
    logic [SW-1:0] header_word, footer_word;

    assign hs       = M_AXIS_TVALID && M_AXIS_TREADY;
    assign data_pop = hs && (((out_st == HEADER) && head.len != 16'd0) ||
                             ((out_st == DATA) && rem != 16'd0));
    assign info_pop = hs && (out_st == FOOTER);

    assign header_word = SW'({16'hAA55, 8'(CHANNEL_ID), 8'(head.start_info),
                              48'(head.start_ts), 32'(head.cfg), 16'h0000});
    assign footer_word = SW'({16'h55AA, head.len, 6'b0, head.flags, drop_count,
                              24'h0, 48'(head.end_ts)});

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            out_st        <= OUT_IDLE;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TDATA  <= '0;
            rem           <= '0;
        end else begin
            case (out_st)
                OUT_IDLE: if (info_cnt != '0) begin
                    M_AXIS_TDATA  <= header_word;
                    M_AXIS_TVALID <= 1'b1;
                    out_st        <= HEADER;
                end
                HEADER: if (hs) begin
                    if (head.len != 16'd0) begin
                        M_AXIS_TDATA <= dmem[d_rd];
                        rem          <= head.len - 16'd1;
                        out_st       <= DATA;
                    end else begin
                        M_AXIS_TDATA <= footer_word;
                        M_AXIS_TLAST <= 1'b1;
                        out_st       <= FOOTER;
                    end
                end
                DATA: if (hs) begin
                    if (rem != 16'd0) begin
                        M_AXIS_TDATA <= dmem[d_rd];
                        rem          <= rem - 16'd1;
                    end else begin
                        M_AXIS_TDATA <= footer_word;
                        M_AXIS_TLAST <= 1'b1;
                        out_st       <= FOOTER;
                    end
                end
                FOOTER: if (hs) begin
                    M_AXIS_TVALID <= 1'b0;
                    M_AXIS_TLAST  <= 1'b0;
                    out_st        <= OUT_IDLE;
                end
                default: out_st <= OUT_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trigger_frame_builder.sv
// Directed bench for trigger_frame_builder: packet framing, stalls, truncation,
// frame drops, missing-end closes and mid-frame reset.
module tb_trigger_frame_builder;
    logic         aclk = 1'b0;
    logic         arst = 1'b1;
    logic [215:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic [127:0] m_tdata;
    logic         m_tvalid, m_tlast;
    logic         m_tready = 1'b0;
    logic [15:0]  drop_count;

    trigger_frame_builder dut (
        .ACLK(aclk), .ARESET(arst),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid),
        .M_AXIS_TREADY(m_tready), .M_AXIS_TLAST(m_tlast),
        .DROP_COUNT(drop_count)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [135:0] got, logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // 0: ready low, 1: ready high, 2: pseudo-random ready
    int rdy_mode = 0;
    always begin
        @(posedge aclk);
        #1;
        m_tready = (rdy_mode == 1) ? 1'b1 :
                   (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    logic [128:0] out_q[$];
    logic         stall_q = 1'b0;
    logic [128:0] held = '0;

    always @(negedge aclk) begin
        if (arst) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q)
                chk("hold", 136'({m_tvalid, m_tlast, m_tdata}), 136'({1'b1, held}));
            if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
            stall_q <= m_tvalid && !m_tready;
            held    <= {m_tlast, m_tdata};
        end
    end

    logic [127:0] exp_d[$];

    function automatic logic [127:0] dword(int f, int i);
        return {32'hDA7A0000 + 32'(f), 64'h0, 32'(i)};
    endfunction

    task automatic send(logic [47:0] ts, logic [7:0] info, logic [31:0] cfg, logic [127:0] smp);
        @(posedge aclk);
        #1;
        s_tdata  = {cfg, ts, info, smp};
        s_tvalid = 1'b1;
    endtask

    task automatic idle();
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(int f, int n, int ts0, logic [31:0] cfg, bit rec);
        for (int i = 0; i < n; i++) begin
            send(48'(ts0 + i), {6'b0, i == n - 1, i == 0}, cfg, dword(f, i));
            if (rec) exp_d.push_back(dword(f, i));
        end
    endtask

    task automatic wait_words(int n, output bit ok);
        int cyc = 0;
        while (out_q.size() < n && cyc < 3000) begin
            @(negedge aclk);
            cyc++;
        end
        ok = out_q.size() >= n;
        if (!ok) chk("timeout", 136'(out_q.size()), 136'(n));
    endtask

    task automatic expect_frame(int len, logic [7:0] sinfo, logic [47:0] sts, logic [31:0] cfg,
                                logic [1:0] flags, logic [15:0] drop, logic [47:0] ets, bit chk_ets);
        bit ok;
        logic [128:0] got, e;
        wait_words(len + 2, ok);
        if (!ok) return;
        got = out_q.pop_front();
        chk("header", 136'(got), 136'({1'b0, 16'hAA55, 8'h00, sinfo, sts, cfg, 16'h0}));
        for (int i = 0; i < len; i++) begin
            got = out_q.pop_front();
            chk("data", 136'(got), 136'({1'b0, exp_d.pop_front()}));
        end
        got = out_q.pop_front();
        e = {1'b1, 16'h55AA, 16'(len), 6'b0, flags, drop, 24'h0, ets};
        if (!chk_ets) begin
            got[47:0] = '0;
            e[47:0]   = '0;
        end
        chk("footer", 136'(got), 136'(e));
    endtask

    initial begin
        logic [31:0] cfg;
        cfg = 32'h1234_5678;
        repeat (3) @(posedge aclk);
        #1 arst = 1'b0;
        @(negedge aclk);
        chk("reset_outs", 136'({m_tvalid, m_tlast, m_tdata, drop_count}), 136'(0));

        // 3-word frame, header latency, ready high
        rdy_mode = 1;
        repeat (2) @(posedge aclk);
        send_frame(1, 3, 100, cfg, 1'b1);
        idle();
        @(posedge aclk);
        @(negedge aclk);
        chk("lat_early", 136'(m_tvalid), 136'(0));
        @(posedge aclk);
        @(negedge aclk);
        chk("lat_hdr", 136'(m_tvalid), 136'(1));
        expect_frame(3, 8'h01, 48'd100, cfg, 2'b00, 16'd0, 48'd102, 1'b1);

        // single word with start=end
        send_frame(2, 1, 7, 32'hCAFE_0002, 1'b1);
        idle();
        expect_frame(1, 8'h03, 48'd7, 32'hCAFE_0002, 2'b00, 16'd0, 48'd7, 1'b1);

        // 10 words under random ready
        rdy_mode = 2;
        send_frame(3, 10, 200, cfg, 1'b1);
        idle();
        expect_frame(10, 8'h01, 48'd200, cfg, 2'b00, 16'd0, 48'd209, 1'b1);

        // 70-word frame into a 64-deep buffer with ready held low
        rdy_mode = 0;
        repeat (3) @(posedge aclk);
        send_frame(4, 70, 1000, cfg, 1'b1);
        while (exp_d.size() > 64) void'(exp_d.pop_back());
        idle();
        repeat (5) @(posedge aclk);
        rdy_mode = 1;
        expect_frame(64, 8'h01, 48'd1000, cfg, 2'b01, 16'd0, 48'd1069, 1'b1);

        // five 2-word frames against a 4-deep info buffer
        rdy_mode = 0;
        repeat (3) @(posedge aclk);
        for (int f = 0; f < 5; f++) send_frame(10 + f, 2, 300 + 10 * f, cfg, f < 4);
        idle();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("drop_count", 136'(drop_count), 136'(1));
        rdy_mode = 1;
        for (int f = 0; f < 4; f++)
            expect_frame(2, 8'h01, 48'(300 + 10 * f), cfg, 2'b00, 16'd1, 48'(301 + 10 * f), 1'b1);

        // new start without end closes the previous frame
        send(48'd20, 8'h01, cfg, dword(20, 0));
        exp_d.push_back(dword(20, 0));
        for (int i = 1; i < 5; i++) begin
            send(48'(20 + i), 8'h00, cfg, dword(20, i));
            exp_d.push_back(dword(20, i));
        end
        send(48'd25, 8'h01, cfg, dword(21, 0));
        send(48'd26, 8'h02, cfg, dword(21, 1));
        exp_d.push_back(dword(21, 0));
        exp_d.push_back(dword(21, 1));
        idle();
        expect_frame(5, 8'h01, 48'd20, cfg, 2'b10, 16'd1, 48'd0, 1'b0);
        expect_frame(2, 8'h01, 48'd25, cfg, 2'b00, 16'd1, 48'd26, 1'b1);

        // reset in the middle of a frame
        send(48'd50, 8'h01, cfg, dword(30, 0));
        send(48'd51, 8'h00, cfg, dword(30, 1));
        send(48'd52, 8'h00, cfg, dword(30, 2));
        @(posedge aclk);
        #1;
        arst     = 1'b1;
        s_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1 arst = 1'b0;
        send(48'd53, 8'h02, cfg, dword(30, 3));
        idle();
        repeat (10) @(posedge aclk);
        @(negedge aclk);
        chk("rst_no_out", 136'(out_q.size()), 136'(0));
        chk("rst_outs", 136'({m_tvalid, m_tlast, m_tdata, drop_count}), 136'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trigger_frame_builder.md
# trigger_frame_builder

Consumer of the `data_trigger` output stream. It collects the triggered sample words of each frame, buffers them, and emits one AXI4-Stream packet per frame: a header word, the data words, then a footer word. It sits between `data_trigger` and the DMA/packet path. The input has no backpressure, so the block absorbs downstream stalls in internal FIFOs and drops or truncates frames when those FIFOs fill.

## Interface
Parameters:
- SAMPLE_DATA_WIDTH, 128, sample payload width (8 samples × 16 bit)
- TRIGGER_INFO_WIDTH, 8, trigger info field; bit0 = frame_start, bit1 = frame_end, others passed through
- TIMESTAMP_WIDTH, 48, timestamp field
- TRIGGER_CONFIG_WIDTH, 32, trigger config snapshot field
- CHANNEL_ID, 0, 8-bit channel tag placed in the header
- DATA_FIFO_DEPTH, 64, data word buffer depth (power of 2, ≤ 65535)
- INFO_FIFO_DEPTH, 4, frame-info buffer depth (power of 2)

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset: synchronous, active-high; clock ACLK
- S_AXIS_TDATA  in  216  {config[215:184], timestamp[183:136], info[135:128], samples[127:0]}
- S_AXIS_TVALID  in  1  input word valid; no TREADY
- M_AXIS_TDATA  out  128  packet word
- M_AXIS_TVALID  out  1  output valid
- M_AXIS_TREADY  in  1  downstream ready
- M_AXIS_TLAST  out  1  high on the footer word only
- DROP_COUNT  out  16  frames dropped whole; saturates at 16'hFFFF

## Operation
Input side (state IN_IDLE / IN_FRAME):
- Words with S_AXIS_TVALID=0 are ignored in every state.
- IN_IDLE, valid word with start=1: if the info FIFO is not full, latch the start timestamp, info and config, then go to IN_FRAME and store the word as data. If the info FIFO is full, drop the whole frame, increment DROP_COUNT, and discard words until that frame's end.
- IN_IDLE, valid word with start=0: discard.
- IN_FRAME, each valid word: push to the data FIFO if not full and increment stored_len (16 bit, saturating). If the data FIFO is full, discard the word and set truncated.
- A word with end=1 (including start=end=1 in the same word) is stored first. Then the frame record {start fields, stored_len, flags, end timestamp} is pushed to the info FIFO and the side returns to IN_IDLE.
- IN_FRAME, word with start=1 and end=0: close the previous frame with missing_end=1, then treat the word as a new frame start using the IN_IDLE rules.
- flags[1:0] = {missing_end, truncated}. Both clear at each accepted start.

Output side (state OUT_IDLE / HEADER / DATA / FOOTER). Transmission is store-and-forward per frame.
- OUT_IDLE → HEADER when the info FIFO is non-empty.
- Header word: [127:112]=16'hAA55, [111:104]=CHANNEL_ID, [103:96]=start info, [95:48]=start timestamp, [47:16]=config, [15:0]=0.
- HEADER → DATA on handshake when stored_len > 0. HEADER → FOOTER on handshake when stored_len = 0.
- DATA pops exactly stored_len words, then goes to FOOTER.
- Footer word: [127:112]=16'h55AA, [111:96]=stored_len, [95:88]={6'b0, flags}, [87:72]=DROP_COUNT snapshot at footer load, [71:48]=0, [47:0]=end timestamp. TLAST=1.
- The info FIFO is popped on the footer handshake, then the side returns to OUT_IDLE.

## Timing
- Reset: M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, DROP_COUNT=0. Both FIFOs are emptied, both FSMs go idle, and any partial frame is discarded. Reset mid-frame produces no footer.
- Input words are registered once. A data FIFO push happens 1 cycle after the word is sampled. The info push happens 1 cycle after the end word is sampled.
- Earliest header TVALID is 2 cycles after the end word is sampled (end word at cycle N → header valid at N+2).
- With TREADY held high the output carries one word per cycle and no bubbles between header, data and footer. Consecutive frames may have a 1-cycle gap.
- While TVALID=1 and TREADY=0, TDATA and TLAST hold stable. TVALID never drops without a handshake.
- A simultaneous push and pop on a full data FIFO counts as not full: the word is accepted.

## Test plan
- Reset, then a 3-word frame (ts 100 start, 102 end), TREADY=1 → header (ts=100), 3 words unchanged, footer len=3, flags=0, ts=102, TLAST only on the footer.
- Single word with start=end=1 at ts 7 → header, 1 data word, footer len=1.
- 10-word frame with TREADY toggling pseudo-randomly → all 12 words in order, TDATA stable during stalls.
- DATA_FIFO_DEPTH=64, 70-word frame, TREADY=0 until the end, then 1 → 64 data words, footer len=64, truncated=1.
- INFO_FIFO_DEPTH=4, five 2-word frames with TREADY=0 → the 5th frame is dropped, DROP_COUNT=1, and the 4 frames that are then released come out intact.
- Start at ts 20, then a new start at ts 25 without an end → first footer missing_end=1, len=5. Separately, ARESET during a frame → no output, all outputs zero.
